stopwatch_core: RTL

- Tick-consuming end of the stopwatch timing path. The tick generator upstream emits one-`clk`-wide pulses at 1 Hz in normal mode and 2 Hz in adjust mode; this block receives those pulses.
- Keeps a BCD MM:SS count with pause/resume, adjust-mode field increment and rollover detection, all synchronous to the system clock.
- Drives the display scanner with four BCD digits and per-field blink enables.

---
 rtl/stopwatch_core.sv | 97 +++++++++
 1 files changed

// File: rtl/stopwatch_core.sv
// BCD MM:SS stopwatch counter: edge-detected ticks, pause/resume, per-field adjust,
// rollover pulse and blink enables for the display scanner.
module stopwatch_core #(
  parameter int MAX_MIN = 59,
  parameter int MAX_SEC = 59
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       tick,
  input  logic       ADJ,
  input  logic       SEL,
  input  logic       pause_pulse,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       rollover,
  output logic       blink_min,
  output logic       blink_sec
);

  localparam logic [7:0] SEC_MAX = {4'(MAX_SEC / 10), 4'(MAX_SEC % 10)};
  localparam logic [7:0] MIN_MAX = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

  typedef enum logic {RUN = 1'b0, PAUSED = 1'b1} run_state_t;

  run_state_t state_q, state_d;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic       tick_prev;
  logic       tick_evt;
  logic       roll_d;

  // Two-digit BCD increment that wraps to 00 after the field maximum.
  function automatic logic [7:0] bcd_wrap_inc(input logic [7:0] v, input logic [7:0] maxv);
    if (v == maxv)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign tick_evt = tick & ~tick_prev;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q   <= RUN;
      sec_q     <= 8'h00;
      min_q     <= 8'h00;
      tick_prev <= 1'b0;
      rollover  <= 1'b0;
      blink_min <= 1'b0;
      blink_sec <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      tick_prev <= tick;
      rollover  <= roll_d;
      blink_min <= ADJ & ~SEL;
      blink_sec <= ADJ & SEL;
    end
  end

  // Tick handling uses the pre-toggle run state; a coincident pause only flips state.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    roll_d  = 1'b0;
    if (pause_pulse)
      state_d = (state_q == RUN) ? PAUSED : RUN;
    if (tick_evt) begin
      if (ADJ) begin
        if (SEL)
          sec_d = bcd_wrap_inc(sec_q, SEC_MAX);
        else
          min_d = bcd_wrap_inc(min_q, MIN_MAX);
      end else if (state_q == RUN) begin
        sec_d = bcd_wrap_inc(sec_q, SEC_MAX);
        if (sec_q == SEC_MAX) begin
          min_d = bcd_wrap_inc(min_q, MIN_MAX);
          roll_d = (min_q == MIN_MAX);
        end
      end
    end
  end

  assign running  = (state_q == RUN);
  assign min_tens = min_q[7:4];
  assign min_ones = min_q[3:0];
  assign sec_tens = sec_q[7:4];
  assign sec_ones = sec_q[3:0];

endmodule
